// File: rtl/pwm_capture.sv
// PWM period/high-time measurement with sticky stuck-high/stuck-low detection.
// Optional macro PWM_CAPTURE_SYNC_EN adds a 2-flop input synchronizer ahead of sampling.
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] active,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] act_cnt_q, act_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             valid_q, valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;
  logic             s_q, s_d_q;
  logic             pulse_in;
  logic             rise;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pulse};
  end

  assign pulse_in = sync_q[1];
`else
  assign pulse_in = pulse;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q   <= 1'b0;
      s_d_q <= 1'b0;
    end else begin
      s_q   <= pulse_in;
      s_d_q <= s_q;
    end
  end

  assign rise = s_q & ~s_d_q;

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    act_cnt_d    = act_cnt_q;
    period_d     = period_q;
    active_d     = active_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    if (!enable) begin
      state_d      = IDLE;
      per_cnt_d    = '0;
      act_cnt_d    = '0;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          act_cnt_d = '0;
          state_d   = ARM;
        end
        ARM: begin
          if (rise) begin
            per_cnt_d = CNT_ONE;
            act_cnt_d = CNT_ONE;
            state_d   = MEAS;
          end
        end
        MEAS: begin
          // A rise wins over saturation, so an all-ones period is still captured.
          if (rise) begin
            period_d     = per_cnt_q;
            active_d     = act_cnt_q;
            valid_d      = 1'b1;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            per_cnt_d    = CNT_ONE;
            act_cnt_d    = CNT_ONE;
          end else if (per_cnt_q == CNT_MAX) begin
            stuck_high_d = s_q;
            stuck_low_d  = ~s_q;
            per_cnt_d    = '0;
            act_cnt_d    = '0;
            state_d      = ARM;
          end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
            if (s_q) act_cnt_d = act_cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      act_cnt_q    <= '0;
      period_q     <= '0;
      active_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      act_cnt_q    <= act_cnt_d;
      period_q     <= period_d;
      active_q     <= active_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign period      = period_q;
  assign active      = active_q;
  assign valid       = valid_q;
  assign stuck_high  = stuck_high_q;
  assign stuck_low   = stuck_low_q;
  assign state_dbg_o = state_q;

endmodule
